// File: rtl/spi_pkg.sv
// Shared types and helpers for the SPI master transfer controller and its baud generator.
package spi_pkg;

  localparam int unsigned BitsDefault = 8;
  localparam int unsigned DivWDefault = 12;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StXfer,
    StTail,
    StDone
  } spi_state_e;

  // Divisor D = (sppr+1) * 2^(spr+1); ranges 2..2048, so 12 bits never truncate.
  function automatic logic [DivWDefault-1:0] spi_divisor(input logic [2:0] sppr,
                                                         input logic [2:0] spr);
    logic [DivWDefault-1:0] base;
    base = DivWDefault'(sppr) + DivWDefault'(1);
    return base << ({1'b0, spr} + 4'd1);
  endfunction

endpackage

// File: rtl/spi_xfer_ctrl_if.sv
// Request/sequencing bus between a requester and the SPI transfer controller.
interface spi_xfer_ctrl_if;

  logic       start;
  logic       cpol;
  logic       cphase;
  logic [2:0] sppr;
  logic [2:0] spr;
  logic       cphase_q;
  logic       cpol_q;
  logic       busy;
  logic       done;
  logic       ss;
  logic       sclk;
  logic       send_data;
  logic       receive_data;
  logic       flag_low;
  logic       flag_high;
  logic       flags_low;
  logic       flags_high;

  // Requester side.
  modport master (
    output start, cpol, cphase, sppr, spr,
    input  cphase_q, cpol_q, busy, done, ss, sclk, send_data, receive_data,
    input  flag_low, flag_high, flags_low, flags_high
  );

  // Controller side.
  modport slave (
    input  start, cpol, cphase, sppr, spr,
    output cphase_q, cpol_q, busy, done, ss, sclk, send_data, receive_data,
    output flag_low, flag_high, flags_low, flags_high
  );

endinterface

// File: rtl/spi_baud_gen.sv
// Baud counter, sclk phase toggle and per-edge flag pulse generation for one SPI frame.
module spi_baud_gen
  import spi_pkg::*;
#(
  parameter int unsigned DIV_W = DivWDefault
) (
  input  logic       PCLK,
  input  logic       PRESETn,
  input  logic       clr,
  input  logic       run,
  input  logic       edge_en,
  input  logic       cpol_q,
  input  logic [2:0] sppr_q,
  input  logic [2:0] spr_q,
  output logic       bc_last,
  output logic       sclk,
  output logic       flag_low,
  output logic       flag_high,
  output logic       flags_low,
  output logic       flags_high
);

  logic [DIV_W-1:0] div;
  logic [DIV_W-1:0] bc_q, bc_d;
  logic             ph_q, ph_d;
  logic             pre_edge;
  logic             at_edge;

  assign div      = DIV_W'(spi_divisor(sppr_q, spr_q));
  assign bc_last  = run && (bc_q == div - DIV_W'(1));
  assign pre_edge = edge_en && (bc_q == div - DIV_W'(2));
  assign at_edge  = edge_en && bc_last;

  // sclk is the idle level xor an edge-parity bit, so it returns to cpol_q after 2*BITS edges.
  assign sclk       = cpol_q ^ ph_q;
  assign flags_low  = pre_edge && !sclk;
  assign flags_high = pre_edge && sclk;
  assign flag_low   = at_edge && !sclk;
  assign flag_high  = at_edge && sclk;

  always_comb begin
    bc_d = bc_q;
    ph_d = ph_q;
    if (clr) begin
      bc_d = '0;
      ph_d = 1'b0;
    end else if (run) begin
      bc_d = bc_last ? '0 : bc_q + DIV_W'(1);
      if (at_edge) begin
        ph_d = ~ph_q;
      end
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      bc_q <= '0;
      ph_q <= 1'b0;
    end else begin
      bc_q <= bc_d;
      ph_q <= ph_d;
    end
  end

endmodule

// File: rtl/spi_xfer_ctrl.sv
// SPI master transfer sequencer: latches a request, frames ss/sclk and strobes the byte shifter.
// Optional back-to-back frames without ss deassertion when SPI_CONT_XFER_EN is defined.
module spi_xfer_ctrl
  import spi_pkg::*;
#(
  parameter int unsigned DIV_W = DivWDefault,
  parameter int unsigned BITS  = BitsDefault
) (
  input logic           PCLK,
  input logic           PRESETn,
  spi_xfer_ctrl_if.slave bus
);

  localparam int unsigned     EcW    = $clog2(2 * BITS + 1);
  localparam logic [EcW-1:0] EcLast = EcW'(2 * BITS - 1);

  spi_state_e     state_q, state_d;
  logic [EcW-1:0] ec_q, ec_d;
  logic           ss_q, ss_d;
  logic           cpol_q, cphase_q;
  logic [2:0]     sppr_q, spr_q;
  logic           cont;
  logic           accept;
  logic           bc_last;
  logic           sclk;
  logic           flag_low, flag_high, flags_low, flags_high;

`ifdef SPI_CONT_XFER_EN
  assign cont = bus.start;
`else
  assign cont = 1'b0;
`endif

  assign accept = ((state_q == StIdle) && bus.start) || ((state_q == StDone) && cont);

  always_comb begin
    state_d = state_q;
    ec_d    = ec_q;
    ss_d    = ss_q;
    unique case (state_q)
      StIdle: begin
        if (bus.start) state_d = StLoad;
      end
      StLoad: begin
        ss_d    = 1'b0;
        ec_d    = '0;
        state_d = StXfer;
      end
      StXfer: begin
        if (bc_last) begin
          ec_d = ec_q + EcW'(1);
          if (ec_q == EcLast) state_d = StTail;
        end
      end
      StTail: begin
        if (bc_last) state_d = StDone;
      end
      StDone: begin
        // A continued frame keeps ss asserted straight into the next load.
        if (cont) begin
          state_d = StLoad;
        end else begin
          state_d = StIdle;
          ss_d    = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q  <= StIdle;
      ec_q     <= '0;
      ss_q     <= 1'b1;
      cpol_q   <= 1'b0;
      cphase_q <= 1'b0;
      sppr_q   <= '0;
      spr_q    <= '0;
    end else begin
      state_q <= state_d;
      ec_q    <= ec_d;
      ss_q    <= ss_d;
      if (accept) begin
        cpol_q   <= bus.cpol;
        cphase_q <= bus.cphase;
        sppr_q   <= bus.sppr;
        spr_q    <= bus.spr;
      end
    end
  end

  spi_baud_gen #(
    .DIV_W(DIV_W)
  ) u_baud (
    .PCLK      (PCLK),
    .PRESETn   (PRESETn),
    .clr       (state_q == StLoad),
    .run       ((state_q == StXfer) || (state_q == StTail)),
    .edge_en   (state_q == StXfer),
    .cpol_q    (cpol_q),
    .sppr_q    (sppr_q),
    .spr_q     (spr_q),
    .bc_last   (bc_last),
    .sclk      (sclk),
    .flag_low  (flag_low),
    .flag_high (flag_high),
    .flags_low (flags_low),
    .flags_high(flags_high)
  );

  assign bus.cpol_q       = cpol_q;
  assign bus.cphase_q     = cphase_q;
  assign bus.busy         = (state_q != StIdle);
  assign bus.send_data    = (state_q == StLoad);
  assign bus.done         = (state_q == StDone);
  assign bus.receive_data = (state_q == StDone);
  assign bus.ss           = ss_q;
  assign bus.sclk         = sclk;
  assign bus.flag_low     = flag_low;
  assign bus.flag_high    = flag_high;
  assign bus.flags_low    = flags_low;
  assign bus.flags_high   = flags_high;

endmodule

// File: tb/tb_spi_xfer_ctrl.sv
// Self-checking bench for spi_xfer_ctrl: table-driven frames checked by a per-frame scoreboard.
module tb_spi_xfer_ctrl;

  logic PCLK    = 1'b0;
  logic PRESETn = 1'b1;

  spi_xfer_ctrl_if bus ();

  spi_xfer_ctrl dut (
    .PCLK   (PCLK),
    .PRESETn(PRESETn),
    .bus    (bus)
  );

  always #5 PCLK = ~PCLK;

  typedef struct {
    logic       cpol;
    logic       cphase;
    logic [2:0] sppr;
    logic [2:0] spr;
    int         d;
  } vec_t;

  typedef struct {
    logic cpol;
    logic cphase;
    int   d;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[7];
  int   checks = 0;
  int   errors = 0;

  // Frame monitor state
  int   frame_starts = 0, frames_done = 0, last_gap = -1, gap_cnt = 0;
  bit   in_frame = 0, after_done = 0;
  int   f_len, toggles = 0, first_lvl, idle_lvl, last_tog, min_sp, max_sp;
  int   fl, fh, fsl, fsh, first_flag, last_flag, ss_low, seq_err;
  logic prev_sclk, prev_fsl = 1'b0, prev_fsh = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic frame_check();
    exp_t e;
    chk("done_expected", int'(sb.size() > 0), 1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("frame_len", f_len, 17 * e.d + 2);
      chk("sclk_toggles", toggles, 16);
      chk("edge_spacing_min", min_sp, e.d);
      chk("edge_spacing_max", max_sp, e.d);
      chk("flag_low_cnt", fl, 8);
      chk("flag_high_cnt", fh, 8);
      chk("flags_low_cnt", fsl, 8);
      chk("flags_high_cnt", fsh, 8);
      chk("sclk_idle_lvl", idle_lvl, int'(e.cpol));
      chk("sclk_first_edge_lvl", first_lvl, int'(!e.cpol));
      chk("first_flag_high", first_flag, int'(e.cpol));
      chk("ss_low_cycles", ss_low, 17 * e.d + 1);
      chk("flag_sequence_errs", seq_err, 0);
      chk("cpol_q", int'(bus.cpol_q), int'(e.cpol));
      chk("cphase_q", int'(bus.cphase_q), int'(e.cphase));
      chk("recv_with_done", int'(bus.receive_data), 1);
      chk("sclk_at_done", int'(bus.sclk), int'(e.cpol));
    end
  endtask

  always @(negedge PCLK) begin
    if (!PRESETn) begin
      in_frame   = 0;
      after_done = 0;
    end else begin
      if (after_done && bus.ss) gap_cnt++;
      if (bus.send_data) begin
        if (after_done) last_gap = gap_cnt;
        after_done = 0;
        gap_cnt    = 0;
        in_frame   = 1;
        frame_starts++;
        f_len      = 0;
        toggles    = 0;
        last_tog   = -1;
        min_sp     = 1 << 30;
        max_sp     = 0;
        fl = 0; fh = 0; fsl = 0; fsh = 0;
        first_flag = -1;
        last_flag  = -1;
        first_lvl  = -1;
        ss_low     = 0;
        seq_err    = 0;
        idle_lvl   = int'(bus.sclk);
        prev_sclk  = bus.sclk;
      end
      if (in_frame) begin
        f_len++;
        if (bus.sclk !== prev_sclk) begin
          toggles++;
          if (toggles == 1) first_lvl = int'(bus.sclk);
          if (last_tog >= 0) begin
            if (f_len - last_tog < min_sp) min_sp = f_len - last_tog;
            if (f_len - last_tog > max_sp) max_sp = f_len - last_tog;
          end
          last_tog = f_len;
        end
        prev_sclk = bus.sclk;
        if (bus.flags_low) fsl++;
        if (bus.flags_high) fsh++;
        if (bus.flag_low) begin
          fl++;
          if (!prev_fsl || bus.sclk || last_flag == 0) seq_err++;
          last_flag = 0;
          if (first_flag < 0) first_flag = 0;
        end
        if (bus.flag_high) begin
          fh++;
          if (!prev_fsh || !bus.sclk || last_flag == 1) seq_err++;
          last_flag = 1;
          if (first_flag < 0) first_flag = 1;
        end
        if ((bus.flag_low || bus.flag_high) && (bus.flags_low || bus.flags_high)) seq_err++;
        if (!bus.send_data && !bus.ss) ss_low++;
        if (bus.done) begin
          frame_check();
          in_frame   = 0;
          after_done = 1;
          frames_done++;
        end
      end
      prev_fsl = bus.flags_low;
      prev_fsh = bus.flags_high;
    end
  end

  task automatic check_reset();
    chk("rst_ss", int'(bus.ss), 1);
    chk("rst_sclk", int'(bus.sclk), 0);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_done", int'(bus.done), 0);
    chk("rst_send", int'(bus.send_data), 0);
    chk("rst_recv", int'(bus.receive_data), 0);
    chk("rst_flags", int'({bus.flag_low, bus.flag_high, bus.flags_low, bus.flags_high}), 0);
    chk("rst_cpol_q", int'(bus.cpol_q), 0);
    chk("rst_cphase_q", int'(bus.cphase_q), 0);
  endtask

  task automatic drive_start(input vec_t v);
    @(negedge PCLK);
    bus.cpol   = v.cpol;
    bus.cphase = v.cphase;
    bus.sppr   = v.sppr;
    bus.spr    = v.spr;
    bus.start  = 1'b1;
    @(posedge PCLK);
    #1;
    bus.start = 1'b0;
    chk("send_latency", int'(bus.send_data), 1);
    chk("busy_on_accept", int'(bus.busy), 1);
  endtask

  task automatic wait_done(input int target, input int budget);
    int n = 0;
    while (frames_done < target && n < budget) begin
      @(posedge PCLK);
      n++;
    end
    chk("frame_timeout", int'(frames_done >= target), 1);
  endtask

  task automatic run_vec(input vec_t v);
    int d0 = frames_done;
    sb.push_back('{v.cpol, v.cphase, v.d});
    drive_start(v);
    wait_done(d0 + 1, 17 * v.d + 64);
    repeat (3) @(negedge PCLK);
  endtask

  initial begin
    vec_t v;
    int   s0, d0, n;
    bus.start = 1'b0; bus.cpol = 1'b0; bus.cphase = 1'b0; bus.sppr = '0; bus.spr = '0;

    vecs[0] = '{1'b0, 1'b0, 3'd0, 3'd0, 2};     // mode 0, minimum divisor
    vecs[1] = '{1'b1, 1'b1, 3'd2, 3'd1, 12};    // mode 3
    vecs[2] = '{1'b0, 1'b1, 3'd1, 3'd0, 4};     // mode 1
    vecs[3] = '{1'b1, 1'b0, 3'd4, 3'd2, 40};    // mode 2
    vecs[4] = '{1'b1, 1'b0, 3'd0, 3'd3, 16};
    vecs[5] = '{1'b0, 1'b1, 3'd6, 3'd0, 14};
    vecs[6] = '{1'b0, 1'b0, 3'd7, 3'd7, 2048};  // maximum divisor

    #1 PRESETn = 1'b0;
    #2 check_reset();
    #9 PRESETn = 1'b1;

    for (int i = 0; i < 7; i++) run_vec(vecs[i]);

    // Start pulses and config changes while busy must not disturb the frame.
    v  = '{1'b0, 1'b0, 3'd2, 3'd1, 12};
    s0 = frame_starts;
    d0 = frames_done;
    sb.push_back('{v.cpol, v.cphase, v.d});
    drive_start(v);
    repeat (30) @(negedge PCLK);
    bus.cpol = 1'b1; bus.cphase = 1'b1; bus.sppr = 3'd7; bus.start = 1'b1;
    @(negedge PCLK);
    bus.start = 1'b0;
    repeat (50) @(negedge PCLK);
    bus.cpol = 1'b0; bus.start = 1'b1;
    @(negedge PCLK);
    bus.start = 1'b0; bus.cpol = 1'b1;
    wait_done(d0 + 1, 17 * 12 + 64);
    repeat (40) @(negedge PCLK);
    chk("busy_no_restart", frame_starts - s0, 1);
    chk("busy_one_done", frames_done - d0, 1);

    // Asynchronous reset in the middle of a frame, at edge count 5.
    drive_start('{1'b1, 1'b1, 3'd1, 3'd0, 4});
    n = 0;
    do begin
      @(negedge PCLK);
      #1;
      n++;
    end while (toggles < 5 && n < 200);
    chk("reset_reach_ec5", int'(toggles >= 5), 1);
    #2 PRESETn = 1'b0;
    #1 check_reset();
    repeat (2) @(negedge PCLK);
    chk("reset_held_busy", int'(bus.busy), 0);
    #2 PRESETn = 1'b1;
    run_vec(vecs[2]);

    // Start held high across two frames.
    v  = '{1'b0, 1'b1, 3'd1, 3'd0, 4};
    s0 = frame_starts;
    d0 = frames_done;
    sb.push_back('{v.cpol, v.cphase, v.d});
    sb.push_back('{v.cpol, v.cphase, v.d});
    @(negedge PCLK);
    bus.cpol = v.cpol; bus.cphase = v.cphase; bus.sppr = v.sppr; bus.spr = v.spr;
    bus.start = 1'b1;
    n = 0;
    while (frame_starts < s0 + 2 && n < 400) begin
      @(negedge PCLK);
      #1;
      n++;
    end
    bus.start = 1'b0;
    chk("held_second_start", int'(frame_starts >= s0 + 2), 1);
    wait_done(d0 + 2, 200);
    repeat (20) @(negedge PCLK);
    chk("held_start_frames", frame_starts - s0, 2);
    chk("held_start_dones", frames_done - d0, 2);
`ifdef SPI_CONT_XFER_EN
    chk("cont_ss_gap", last_gap, 0);
`else
    chk("idle_ss_gap", int'(last_gap >= 1), 1);
`endif
    chk("scoreboard_drained", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
